// File: rtl/sdram_pkg.sv
// Shared encodings for the SDRAM device-side responder: command codes, init FSM states,
// violation codes and the read-pipeline slot type.
package sdram_pkg;

  // {ras_n, cas_n, we_n} with cs_n=0 and clock_enable=1
  typedef enum logic [2:0] {
    CmdMrs   = 3'b000,
    CmdRef   = 3'b001,
    CmdPre   = 3'b010,
    CmdAct   = 3'b011,
    CmdWrite = 3'b100,
    CmdRead  = 3'b101,
    CmdBst   = 3'b110,
    CmdNop   = 3'b111
  } sdram_cmd_e;

  typedef enum logic [2:0] {
    StWaitPre,
    StWaitRef1,
    StWaitRef2,
    StWaitMrs,
    StReady
  } init_state_e;

  localparam logic [3:0] ErrNone       = 4'd0;
  localparam logic [3:0] ErrInitOrder  = 4'd1;
  localparam logic [3:0] ErrActOpen    = 4'd2;
  localparam logic [3:0] ErrClosedBank = 4'd3;
  localparam logic [3:0] ErrModeWord   = 4'd4;
  localparam logic [3:0] ErrUnsupCmd   = 4'd5;
  localparam logic [3:0] ErrTrcd       = 4'd6;
  localparam logic [3:0] ErrTrp        = 4'd7;
  localparam logic [3:0] ErrTrfc       = 4'd8;
  localparam logic [3:0] ErrRefOverdue = 4'd9;

  // One read data slot travelling down the CAS-latency pipeline
  typedef struct packed {
    logic        valid;
    logic        drv;
    logic [15:0] data;
  } rd_slot_t;

  // Only CL 2/3 with burst length 1 are supported
  function automatic logic mode_word_ok(input logic [2:0] cl, input logic [2:0] bl);
    return ((cl == 3'd2) || (cl == 3'd3)) && (bl == 3'd0);
  endfunction

endpackage

// File: rtl/sdram_resp_rdpipe.sv
// CAS-latency shift pipeline: a READ pushes a slot on its command edge, and the slot
// reaches the output register exactly CL edges later for one cycle.
module sdram_resp_rdpipe
  import sdram_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_push,
  input  logic        i_mask_both,
  input  logic [15:0] i_data,
  input  logic [2:0]  i_cl,
  output logic        o_drive,
  output logic [15:0] o_data
);

  rd_slot_t r_stage [3];
  rd_slot_t r_out;

  // Shift slots each edge; the output taps stage CL-1 so data lands on edge N+CL
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 3; i++) r_stage[i] <= '0;
      r_out <= '0;
    end else begin
      r_stage[0] <= '{valid: i_push, drv: i_push & ~i_mask_both, data: i_data};
      r_stage[1] <= r_stage[0];
      r_stage[2] <= r_stage[1];
      r_out      <= (i_cl == 3'd2) ? r_stage[1] : r_stage[2];
    end
  end

  assign o_drive = r_out.valid & r_out.drv;
  assign o_data  = r_out.data;

endmodule

// File: rtl/sdram_responder.sv
// SDRAM device-side responder: decodes controller commands, tracks open rows, serves an
// aliased on-chip store with the programmed CAS latency and latches the first violation.
// Optional timing checks (tRCD/tRP/tRFC/refresh interval) under SDRAM_RESP_TIMING_CHECK_EN.
module sdram_responder
  import sdram_pkg::*;
#(
  parameter int unsigned ROW_WIDTH        = 13,
  parameter int unsigned COL_WIDTH        = 9,
  parameter int unsigned BANK_WIDTH       = 2,
  parameter int unsigned MEM_ROW_BITS     = 2,
  parameter int unsigned T_RCD            = 2,
  parameter int unsigned T_RP             = 2,
  parameter int unsigned T_RFC            = 8,
  parameter int unsigned REF_INTERVAL_MAX = 1040
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [ROW_WIDTH-1:0]  i_addr,
  input  logic [BANK_WIDTH-1:0] i_bank_addr,
  inout  wire  [15:0]           io_data,
  input  logic                  i_clock_enable,
  input  logic                  i_cs_n,
  input  logic                  i_ras_n,
  input  logic                  i_cas_n,
  input  logic                  i_we_n,
  input  logic                  i_data_mask_low,
  input  logic                  i_data_mask_high,
  output logic                  o_init_done,
  output logic                  o_error,
  output logic [3:0]            o_error_code
);

  localparam int unsigned NumBanks = 1 << BANK_WIDTH;
  localparam int unsigned IdxW     = BANK_WIDTH + MEM_ROW_BITS + COL_WIDTH;
  localparam int unsigned MemDepth = 1 << IdxW;

  init_state_e r_state, w_state_next;
  sdram_cmd_e  w_cmd;
  logic        r_init_done, r_error;
  logic [3:0]  r_error_code;
  logic [2:0]  r_cl;
  logic [NumBanks-1:0]                r_bank_open;
  logic [NumBanks-1:0][ROW_WIDTH-1:0] r_open_row;
  logic [15:0] r_mem [MemDepth];

  logic        w_err, w_terr, w_mode_ok;
  logic [3:0]  w_err_code, w_terr_code;
  logic        w_do_act, w_do_pre, w_do_rd, w_do_wr, w_do_mrs;
  logic [IdxW-1:0] w_idx;
  logic        w_rd_drive;
  logic [15:0] w_rd_data;
  logic        w_unused_rows;

  assign w_cmd = (i_clock_enable && !i_cs_n) ? sdram_cmd_e'({i_ras_n, i_cas_n, i_we_n}) : CmdNop;
  assign w_mode_ok = mode_word_ok(i_addr[6:4], i_addr[2:0]);
  assign w_idx = {i_bank_addr, r_open_row[i_bank_addr][MEM_ROW_BITS-1:0], i_addr[COL_WIDTH-1:0]};
  // Upper row bits alias in the store; they are tracked but never index it
  assign w_unused_rows = ^r_open_row;

  // Init sequencing, command legality and protocol violation decode
  always_comb begin
    w_state_next = r_state;
    w_err        = 1'b0;
    w_err_code   = ErrNone;
    w_do_act     = 1'b0;
    w_do_pre     = 1'b0;
    w_do_rd      = 1'b0;
    w_do_wr      = 1'b0;
    w_do_mrs     = 1'b0;
    if (r_state != StReady) begin
      if (w_cmd != CmdNop) begin
        if (r_state == StWaitPre && w_cmd == CmdPre && i_addr[10]) begin
          w_state_next = StWaitRef1;
        end else if (r_state == StWaitRef1 && w_cmd == CmdRef) begin
          w_state_next = StWaitRef2;
        end else if (r_state == StWaitRef2 && w_cmd == CmdRef) begin
          w_state_next = StWaitMrs;
        end else if (r_state == StWaitMrs && w_cmd == CmdMrs) begin
          if (w_mode_ok) begin
            w_state_next = StReady;
            w_do_mrs     = 1'b1;
          end else begin
            w_err      = 1'b1;
            w_err_code = ErrModeWord;
          end
        end else begin
          w_err      = 1'b1;
          w_err_code = ErrInitOrder;
        end
      end
    end else begin
      unique case (w_cmd)
        CmdMrs: begin
          if (w_mode_ok) w_do_mrs = 1'b1;
          else begin
            w_err      = 1'b1;
            w_err_code = ErrModeWord;
          end
        end
        CmdPre: w_do_pre = 1'b1;
        CmdAct: begin
          if (r_bank_open[i_bank_addr]) begin
            w_err      = 1'b1;
            w_err_code = ErrActOpen;
          end else w_do_act = 1'b1;
        end
        CmdWrite, CmdRead: begin
          if (!r_bank_open[i_bank_addr]) begin
            w_err      = 1'b1;
            w_err_code = ErrClosedBank;
          end else if (w_cmd == CmdWrite) w_do_wr = 1'b1;
          else w_do_rd = 1'b1;
        end
        CmdBst: begin
          w_err      = 1'b1;
          w_err_code = ErrUnsupCmd;
        end
        CmdRef, CmdNop: ;
        default: ;
      endcase
    end
  end

  // FSM state, init_done (one edge after MRS acceptance), CAS latency and sticky error
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state      <= StWaitPre;
      r_init_done  <= 1'b0;
      r_cl         <= 3'd3;
      r_error      <= 1'b0;
      r_error_code <= ErrNone;
    end else begin
      r_state     <= w_state_next;
      r_init_done <= (r_state == StReady);
      if (w_do_mrs) r_cl <= i_addr[6:4];
      if (!r_error && (w_err || w_terr)) begin
        r_error      <= 1'b1;
        r_error_code <= w_err ? w_err_code : w_terr_code;
      end
    end
  end

  // Bank table: open flag and row per bank; A10 on an access auto-precharges
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_bank_open <= '0;
      r_open_row  <= '0;
    end else begin
      if (w_do_act) begin
        r_bank_open[i_bank_addr] <= 1'b1;
        r_open_row[i_bank_addr]  <= i_addr;
      end
      if (w_do_pre) begin
        if (i_addr[10]) r_bank_open <= '0;
        else r_bank_open[i_bank_addr] <= 1'b0;
      end
      if ((w_do_rd || w_do_wr) && i_addr[10]) r_bank_open[i_bank_addr] <= 1'b0;
    end
  end

  // Byte-masked store write on the command edge; contents survive reset
  always_ff @(posedge i_clk) begin
    if (w_do_wr) begin
      if (!i_data_mask_low)  r_mem[w_idx][7:0]  <= io_data[7:0];
      if (!i_data_mask_high) r_mem[w_idx][15:8] <= io_data[15:8];
    end
  end

  sdram_resp_rdpipe u_rdpipe (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_push      (w_do_rd),
    .i_mask_both (i_data_mask_low & i_data_mask_high),
    .i_data      (r_mem[w_idx]),
    .i_cl        (r_cl),
    .o_drive     (w_rd_drive),
    .o_data      (w_rd_data)
  );

  assign io_data      = w_rd_drive ? w_rd_data : 16'bz;
  assign o_init_done  = r_init_done;
  assign o_error      = r_error;
  assign o_error_code = r_error_code;

`ifdef SDRAM_RESP_TIMING_CHECK_EN
  localparam int unsigned     CntW   = 16;
  localparam logic [CntW-1:0] CntMax = '1;
  localparam logic [CntW-1:0] RcdLim = CntW'(T_RCD);
  localparam logic [CntW-1:0] RpLim  = CntW'(T_RP);
  localparam logic [CntW-1:0] RfcLim = CntW'(T_RFC);
  localparam logic [CntW-1:0] RefLim = CntW'(REF_INTERVAL_MAX);

  logic [CntW-1:0] r_rcd_cnt [NumBanks];
  logic [CntW-1:0] r_rp_cnt  [NumBanks];
  logic [CntW-1:0] r_rfc_cnt, r_ref_cnt;

  // Saturating cycle counters since last ACT/PRE per bank, last REF, and refresh age
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int b = 0; b < NumBanks; b++) begin
        r_rcd_cnt[b] <= CntMax;
        r_rp_cnt[b]  <= CntMax;
      end
      r_rfc_cnt <= CntMax;
      r_ref_cnt <= '0;
    end else begin
      for (int b = 0; b < NumBanks; b++) begin
        if (w_cmd == CmdAct && i_bank_addr == BANK_WIDTH'(b)) r_rcd_cnt[b] <= CntW'(1);
        else if (r_rcd_cnt[b] != CntMax) r_rcd_cnt[b] <= r_rcd_cnt[b] + CntW'(1);
        if (w_cmd == CmdPre && (i_addr[10] || i_bank_addr == BANK_WIDTH'(b)))
          r_rp_cnt[b] <= CntW'(1);
        else if (r_rp_cnt[b] != CntMax) r_rp_cnt[b] <= r_rp_cnt[b] + CntW'(1);
      end
      if (w_cmd == CmdRef) r_rfc_cnt <= CntW'(1);
      else if (r_rfc_cnt != CntMax) r_rfc_cnt <= r_rfc_cnt + CntW'(1);
      if (w_cmd == CmdRef || r_state != StReady) r_ref_cnt <= '0;
      else if (r_ref_cnt != CntMax) r_ref_cnt <= r_ref_cnt + CntW'(1);
    end
  end

  // Timing violations; the offending command still executes
  always_comb begin
    w_terr      = 1'b0;
    w_terr_code = ErrNone;
    if (r_state == StReady && w_cmd != CmdRef && r_ref_cnt >= RefLim) begin
      w_terr      = 1'b1;
      w_terr_code = ErrRefOverdue;
    end
    if ((w_cmd == CmdRead || w_cmd == CmdWrite) && r_rcd_cnt[i_bank_addr] < RcdLim) begin
      w_terr      = 1'b1;
      w_terr_code = ErrTrcd;
    end
    if (w_cmd == CmdAct && r_rp_cnt[i_bank_addr] < RpLim) begin
      w_terr      = 1'b1;
      w_terr_code = ErrTrp;
    end
    if (w_cmd == CmdRef) begin
      for (int b = 0; b < NumBanks; b++) begin
        if (r_rp_cnt[b] < RpLim) begin
          w_terr      = 1'b1;
          w_terr_code = ErrTrp;
        end
      end
    end
    if (w_cmd != CmdNop && r_rfc_cnt < RfcLim) begin
      w_terr      = 1'b1;
      w_terr_code = ErrTrfc;
    end
  end
`else
  logic w_unused_timing;
  assign w_unused_timing = ^{T_RCD, T_RP, T_RFC, REF_INTERVAL_MAX};
  assign w_terr          = 1'b0;
  assign w_terr_code     = ErrNone;
`endif

endmodule

// File: tb/tb_sdram_responder.sv
// Directed self-checking bench for sdram_responder. The DQ bus is pulled up, so a
// released (high-Z) bus reads as 16'hFFFF.
module tb_sdram_responder;

  localparam logic [2:0] MRS = 3'b000, REF = 3'b001, PRE = 3'b010, ACT = 3'b011;
  localparam logic [2:0] WR  = 3'b100, RD  = 3'b101, NOP = 3'b111;
  localparam logic [15:0] HIZ = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] addr;
  logic [1:0]  bank_addr;
  logic        cke, cs_n, ras_n, cas_n, we_n, dml, dmh;
  logic        dq_oe;
  logic [15:0] dq_drv;
  wire  [15:0] data;
  logic        init_done, error;
  logic [3:0]  error_code;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  assign data = dq_oe ? dq_drv : 16'bz;
  for (genvar g = 0; g < 16; g++) begin : g_pu
    pullup (data[g]);
  end

  sdram_responder dut (
    .i_clk            (clk),
    .i_rst_n          (rst_n),
    .i_addr           (addr),
    .i_bank_addr      (bank_addr),
    .io_data          (data),
    .i_clock_enable   (cke),
    .i_cs_n           (cs_n),
    .i_ras_n          (ras_n),
    .i_cas_n          (cas_n),
    .i_we_n           (we_n),
    .i_data_mask_low  (dml),
    .i_data_mask_high (dmh),
    .o_init_done      (init_done),
    .o_error          (error),
    .o_error_code     (error_code)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Idle cycles; returns 2 time units after the n-th edge
  task automatic nop(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // One command on the next edge; returns 2 time units after that edge
  task automatic cmd(input logic [2:0] c, input logic [1:0] b, input logic [12:0] a,
                     input logic oe = 1'b0, input logic [15:0] d = 16'h0,
                     input logic ml = 1'b0, input logic mh = 1'b0);
    {ras_n, cas_n, we_n} = c;
    cs_n = 1'b0; bank_addr = b; addr = a;
    dq_oe = oe; dq_drv = d; dml = ml; dmh = mh;
    @(posedge clk);
    #1;
    {ras_n, cas_n, we_n} = NOP;
    cs_n = 1'b1; dq_oe = 1'b0; dml = 1'b0; dmh = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    nop(2);
    rst_n = 1'b1;
    nop(1);
  endtask

  task automatic do_init(input logic [12:0] mode);
    do_reset();
    cmd(PRE, 2'd0, 13'h400);
    nop(2);
    cmd(REF, 2'd0, 13'h0);
    nop(8);
    cmd(REF, 2'd0, 13'h0);
    nop(8);
    cmd(MRS, 2'd0, mode);
    nop(1);
  endtask

  initial begin
    rst_n = 1'b0; addr = '0; bank_addr = '0; cke = 1'b1; cs_n = 1'b1;
    {ras_n, cas_n, we_n} = NOP; dml = 1'b0; dmh = 1'b0; dq_oe = 1'b0; dq_drv = '0;

    // Reset state
    nop(2);
    check("rst_init_done", 16'(init_done), 16'd0);
    check("rst_error", 16'(error), 16'd0);
    check("rst_error_code", 16'(error_code), 16'd0);
    check("rst_bus_hiz", data, HIZ);

    // Controller init with CL=3
    do_init(13'h230);
    check("init_done", 16'(init_done), 16'd1);
    check("init_no_error", 16'(error), 16'd0);

    // Write, precharge, reopen, read at CL=3
    cmd(ACT, 2'd1, 13'd5);
    nop(2);
    cmd(WR, 2'd1, 13'd7, 1'b1, 16'hA55A);
    cmd(WR, 2'd1, 13'd8, 1'b1, 16'h5678);
    cmd(PRE, 2'd1, 13'd0);
    nop(2);
    cmd(ACT, 2'd1, 13'd5);
    nop(2);
    cmd(RD, 2'd1, 13'd7);
    nop(2);
    check("rd_cl3_edge_n2", data, HIZ);
    nop(1);
    check("rd_cl3_edge_n3", data, 16'hA55A);
    nop(1);
    check("rd_cl3_edge_n4", data, HIZ);

    // Masked write keeps the high byte
    cmd(WR, 2'd1, 13'd7, 1'b1, 16'h1234, 1'b0, 1'b1);
    cmd(RD, 2'd1, 13'd7);
    nop(3);
    check("rd_masked_write", data, 16'hA534);

    // Back-to-back reads occupy consecutive slots
    cmd(RD, 2'd1, 13'd7);
    cmd(RD, 2'd1, 13'd8);
    nop(2);
    check("b2b_slot0", data, 16'hA534);
    nop(1);
    check("b2b_slot1", data, 16'h5678);
    nop(1);
    check("b2b_after", data, HIZ);

    // Both masks at the READ edge leave the slot undriven
    cmd(RD, 2'd1, 13'd7, 1'b0, 16'h0, 1'b1, 1'b1);
    nop(3);
    check("rd_both_masked", data, HIZ);

    // WRITE on the read output cycle: read returns the pre-write value
    cmd(RD, 2'd1, 13'd7);
    nop(2);
    cmd(WR, 2'd1, 13'd7, 1'b1, 16'hBEEF);
    check("rd_during_wr", data, 16'hA534);
    nop(1);
    cmd(RD, 2'd1, 13'd7);
    nop(3);
    check("rd_after_wr", data, 16'hBEEF);
    check("no_error_so_far", 16'(error), 16'd0);

    // ACT to an open bank, then a later closed-bank READ does not overwrite the code
    cmd(ACT, 2'd1, 13'd9);
    nop(1);
    check("act_open_error", 16'(error), 16'd1);
    check("act_open_code", 16'(error_code), 16'd2);
    cmd(PRE, 2'd0, 13'h400);
    nop(2);
    cmd(RD, 2'd1, 13'd7);
    nop(3);
    check("closed_rd_dropped", data, HIZ);
    check("first_code_kept", 16'(error_code), 16'd2);

    // READ before init completes
    do_reset();
    cmd(PRE, 2'd0, 13'h400);
    nop(2);
    cmd(RD, 2'd1, 13'd7);
    nop(1);
    check("early_rd_error", 16'(error), 16'd1);
    check("early_rd_code", 16'(error_code), 16'd1);
    check("early_rd_not_init", 16'(init_done), 16'd0);

    // Illegal CAS latency in the mode word
    do_reset();
    cmd(PRE, 2'd0, 13'h400);
    nop(2);
    cmd(REF, 2'd0, 13'h0);
    nop(8);
    cmd(REF, 2'd0, 13'h0);
    nop(8);
    cmd(MRS, 2'd0, 13'h050);
    nop(2);
    check("bad_mrs_code", 16'(error_code), 16'd4);
    check("bad_mrs_not_init", 16'(init_done), 16'd0);

    // CL=2; store survives reset
    do_init(13'h020);
    check("cl2_init_done", 16'(init_done), 16'd1);
    cmd(ACT, 2'd1, 13'd5);
    nop(2);
    cmd(RD, 2'd1, 13'd7);
    nop(1);
    check("rd_cl2_edge_n1", data, HIZ);
    nop(1);
    check("rd_cl2_edge_n2", data, 16'hBEEF);
    nop(1);
    check("rd_cl2_edge_n3", data, HIZ);

    // Reset mid-read cancels the pending slot
    cmd(RD, 2'd1, 13'd7);
    nop(1);
    rst_n = 1'b0;
    nop(1);
    check("rst_mid_read_hiz", data, HIZ);
    check("rst_mid_read_init", 16'(init_done), 16'd0);
    rst_n = 1'b1;

    // READ one cycle after ACT
    do_init(13'h230);
    cmd(ACT, 2'd2, 13'd3);
    cmd(RD, 2'd2, 13'd0);
    nop(1);
`ifdef SDRAM_RESP_TIMING_CHECK_EN
    check("trcd_error", 16'(error), 16'd1);
    check("trcd_code", 16'(error_code), 16'd6);
`else
    check("no_timing_error", 16'(error), 16'd0);
    check("no_timing_code", 16'(error_code), 16'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
